// File: rtl/lt_spi_pkg.sv
// Shared definitions for the SPI burst register bank.
//   - Command word layout: CMD_W bits, bit CMD_WR_BIT selects write, low ADDR_W bits are the start address.
//   - FSM state encodings, kept as plain localparam constants so older tools can consume them.
// Configuration macro recognised by the design: LT_SPI_ATOMIC_EN (S_COMMIT is only reachable when it is defined).
package lt_spi_pkg;

    localparam int CMD_W      = 8;
    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_W     = 7;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_CMD    = 2'd1;
    localparam state_t S_DATA   = 2'd2;
    localparam state_t S_COMMIT = 2'd3;

endpackage

// File: rtl/lt_spi_burst_regbank_if.sv
// SPI pin bundle between a host (master) and the register bank (slave).
//   MySPI_clk  SPI clock, mode 0
//   MySPI_cs   chip select, active low
//   MySPI_sdi  serial data towards the slave, MSB first
//   MySPI_sdo  serial data from the slave, MSB first
interface lt_spi_burst_regbank_if;

    logic MySPI_clk;
    logic MySPI_cs;
    logic MySPI_sdi;
    logic MySPI_sdo;

    modport slave  (input  MySPI_clk, input  MySPI_cs, input  MySPI_sdi, output MySPI_sdo);
    modport master (output MySPI_clk, output MySPI_cs, output MySPI_sdi, input  MySPI_sdo);

endinterface

// File: rtl/lt_spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous single-bit input with one-cycle edge pulses.
//   clk_i   system clock
//   rst_i   asynchronous active-high reset (flops load RST_VAL)
//   d_i     asynchronous input
//   rise_o  one-cycle pulse after the synchronised input goes 0->1
//   fall_o  one-cycle pulse after the synchronised input goes 1->0
// RST_VAL should match the idle level of the input so that leaving reset produces no edge.
module lt_spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {RST_VAL, RST_VAL};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o =  sync_q[1] & ~prev_q;
    assign fall_o = ~sync_q[1] &  prev_q;

endmodule

// File: rtl/lt_spi_burst_regbank.sv
// SPI mode-0 slave register bank with auto-incrementing burst access.
//   theClock   system clock (>= 4x SPI clock)
//   theReset   asynchronous active-high reset
//   spi        SPI pins (slave modport)
//   rw_regs    NUM_RW host-writable registers, reg i at [i*DATA_W +: DATA_W]
//   ro_regs    NUM_RO status inputs, readable at addresses NUM_RW..NUM_RW+NUM_RO-1
//   wr_strobe  one-cycle pulse on bit i when reg i is written
//   frame_err  one-cycle pulse when CS rises in the middle of a word
// Frame: CS low, command {W, A[6:0]}, then DATA_W-bit words; the address advances per word (mod 128).
// Macro LT_SPI_ATOMIC_EN: write words are staged in a shadow copy and applied together in S_COMMIT when CS
// rises; without it every completed word is written straight into the register array.
module lt_spi_burst_regbank
    import lt_spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_RW = 16,
    parameter int NUM_RO = 8
) (
    input  logic                       theClock,
    input  logic                       theReset,
    lt_spi_burst_regbank_if.slave      spi,
    output logic [NUM_RW*DATA_W-1:0]   rw_regs,
    input  logic [NUM_RO*DATA_W-1:0]   ro_regs,
    output logic [NUM_RW-1:0]          wr_strobe,
    output logic                       frame_err
);

    localparam int          RW_IDX_W = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
    localparam logic [5:0]  CMD_LAST = 6'(CMD_W - 1);
    localparam logic [5:0]  DAT_LAST = 6'(DATA_W - 1);

    logic               sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
    logic [1:0]         sdi_q;
    logic               sdi_s;

    state_t             state_q, state_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  regs_q [NUM_RW];
    logic [DATA_W-1:0]  regs_d [NUM_RW];
    logic [NUM_RW-1:0]  strobe_q, strobe_d;
    logic               ferr_q, ferr_d;

    logic [DATA_W-1:0]  shift_in_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [DATA_W-1:0]  rd_word_s;
    logic               addr_in_rw_s;
    int                 ro_base_s;

`ifdef LT_SPI_ATOMIC_EN
    logic [DATA_W-1:0]  shadow_q [NUM_RW];
    logic [DATA_W-1:0]  shadow_d [NUM_RW];
    logic [NUM_RW-1:0]  dirty_q, dirty_d;
`endif

    lt_spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk_i(theClock), .rst_i(theReset), .d_i(spi.MySPI_clk), .rise_o(sck_rise_s), .fall_o(sck_fall_s)
    );

    lt_spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i(theClock), .rst_i(theReset), .d_i(spi.MySPI_cs), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );

    // sdi needs the same two-flop latency as the clock path so the bit lines up with the rise pulse.
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            sdi_q <= 2'b00;
        end else begin
            sdi_q <= {sdi_q[0], spi.MySPI_sdi};
        end
    end

    assign sdi_s        = sdi_q[1];
    assign shift_in_s   = {rx_q, sdi_s};
    assign addr_in_rw_s = (int'(addr_q) < NUM_RW);

    // Address whose contents are loaded into tx at the next word boundary.
    always_comb begin
        if (state_q == S_CMD) begin
            rd_addr_s = shift_in_s[ADDR_W-1:0];
        end else begin
            rd_addr_s = addr_q + 7'd1;
        end
    end

    // Read mux: RW registers, then status inputs, zero beyond the populated range.
    always_comb begin
        rd_word_s = '0;
        ro_base_s = (int'(rd_addr_s) - NUM_RW) * DATA_W;
        if (int'(rd_addr_s) < NUM_RW) begin
            rd_word_s = regs_q[rd_addr_s[RW_IDX_W-1:0]];
        end else if (int'(rd_addr_s) < NUM_RW + NUM_RO) begin
            rd_word_s = ro_regs[ro_base_s +: DATA_W];
        end else begin
            rd_word_s = '0;
        end
    end

    // Frame FSM, shift registers, address counter and register writes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        regs_d    = regs_q;
        strobe_d  = '0;
        ferr_d    = 1'b0;
`ifdef LT_SPI_ATOMIC_EN
        shadow_d  = shadow_q;
        dirty_d   = dirty_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 6'd0;
                    tx_d      = '0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CMD: begin
                if (cs_rise_s) begin
                    state_d = S_IDLE;
                    ferr_d  = (bit_cnt_q != 6'd0);
                end else if (sck_rise_s) begin
                    rx_d = shift_in_s[DATA_W-2:0];
                    if (bit_cnt_q == CMD_LAST) begin
                        wr_d      = shift_in_s[CMD_WR_BIT];
                        addr_d    = shift_in_s[ADDR_W-1:0];
                        tx_d      = rd_word_s;
                        bit_cnt_d = 6'd0;
                        state_d   = S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else begin
                    state_d = S_CMD;
                end
            end
            S_DATA: begin
                if (cs_rise_s) begin
                    ferr_d  = (bit_cnt_q != 6'd0);
`ifdef LT_SPI_ATOMIC_EN
                    state_d = S_COMMIT;
`else
                    state_d = S_IDLE;
`endif
                end else if (sck_rise_s) begin
                    rx_d = shift_in_s[DATA_W-2:0];
                    if (bit_cnt_q == DAT_LAST) begin
                        if (wr_q && addr_in_rw_s) begin
`ifdef LT_SPI_ATOMIC_EN
                            shadow_d[addr_q[RW_IDX_W-1:0]] = shift_in_s;
                            dirty_d[addr_q[RW_IDX_W-1:0]]  = 1'b1;
`else
                            regs_d[addr_q[RW_IDX_W-1:0]]   = shift_in_s;
                            strobe_d[addr_q[RW_IDX_W-1:0]] = 1'b1;
`endif
                        end else begin
                            strobe_d = '0;
                        end
                        addr_d    = addr_q + 7'd1;
                        tx_d      = rd_word_s;
                        bit_cnt_d = 6'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else if (sck_fall_s && (bit_cnt_q != 6'd0)) begin
                    // The fall right after a word boundary must keep the freshly loaded MSB on sdo.
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LT_SPI_ATOMIC_EN
            S_COMMIT: begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (dirty_q[i]) begin
                        regs_d[i] = shadow_q[i];
                    end else begin
                        regs_d[i] = regs_q[i];
                    end
                end
                strobe_d = dirty_q;
                dirty_d  = '0;
                state_d  = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 6'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            regs_q    <= '{default: '0};
            strobe_q  <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            regs_q    <= regs_d;
            strobe_q  <= strobe_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef LT_SPI_ATOMIC_EN
    // Shadow copy and dirty mask for frame-atomic updates.
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            shadow_q <= '{default: '0};
            dirty_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end
`endif

    for (genvar g = 0; g < NUM_RW; g++) begin : g_pack
        assign rw_regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_strobe     = strobe_q;
    assign frame_err     = ferr_q;
    assign spi.MySPI_sdo = tx_q[DATA_W-1];

endmodule

// File: tb/tb_lt_spi_burst_regbank.sv
// Directed testbench for lt_spi_burst_regbank (DATA_W=8, NUM_RW=16, NUM_RO=8).
// Drives SPI mode-0 frames with a 160 ns SPI period against a 10 ns system clock.
// Honours LT_SPI_ATOMIC_EN where the expected commit timing differs.
module tb_lt_spi_burst_regbank;

    localparam int  DATA_W = 8;
    localparam int  NUM_RW = 16;
    localparam int  NUM_RO = 8;
    localparam time H      = 80;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_RW*DATA_W-1:0]  rw_regs;
    logic [NUM_RO*DATA_W-1:0]  ro_regs;
    logic [NUM_RW-1:0]         wr_strobe;
    logic                      frame_err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int strobe_cnt [NUM_RW];
    int strobe_q [$];
    int strobe_t [$];
    int ferr_cnt = 0;

    lt_spi_burst_regbank_if bus ();

    lt_spi_burst_regbank #(.DATA_W(DATA_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO)) dut (
        .theClock (clk),
        .theReset (rst),
        .spi      (bus),
        .rw_regs  (rw_regs),
        .ro_regs  (ro_regs),
        .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (rst === 1'b0) begin
            if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_strobe[i] === 1'b1) begin
                    strobe_cnt[i] = strobe_cnt[i] + 1;
                    strobe_q.push_back(i);
                    strobe_t.push_back(cycle);
                end
            end
        end
    end

    function automatic logic [7:0] rr(input int i);
        return rw_regs[i*8 +: 8];
    endfunction

    task automatic clear_mon();
        for (int i = 0; i < NUM_RW; i++) strobe_cnt[i] = 0;
        strobe_q.delete();
        strobe_t.delete();
        ferr_cnt = 0;
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.MySPI_sdi = v[i];
            #(H);
            rx = {rx[30:0], bus.MySPI_sdo};
            bus.MySPI_clk = 1'b1;
            #(H);
            bus.MySPI_clk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        bus.MySPI_cs = 1'b0;
        #(H);
    endtask

    task automatic frame_end();
        #(H);
        bus.MySPI_cs = 1'b1;
        #(4*H);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.MySPI_cs = 1'b1; bus.MySPI_clk = 1'b0; bus.MySPI_sdi = 1'b0;
        ro_regs = '0;
        #22;
        checks++; if (rw_regs !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", rw_regs); end
        checks++; if (wr_strobe !== '0) begin errors++; $display("FAIL reset_strobe: got %h want 0", wr_strobe); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (bus.MySPI_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", bus.MySPI_sdo); end
        @(negedge clk);
        rst = 1'b0;
        #(H);
        checks++; if (rw_regs !== '0) begin errors++; $display("FAIL post_reset_regs: got %h want 0", rw_regs); end
    endtask

    task automatic test_single_write();
        logic [31:0] rx;
        clear_mon();
        frame_begin();
        spi_bits(32'h83, 8, rx);
        spi_bits(32'hA5, 8, rx);
        #(H);
`ifdef LT_SPI_ATOMIC_EN
        checks++; if (rr(3) !== 8'h00) begin errors++; $display("FAIL staged_reg3: got %h want 00", rr(3)); end
`else
        checks++; if (rr(3) !== 8'hA5) begin errors++; $display("FAIL early_reg3: got %h want a5", rr(3)); end
`endif
        frame_end();
        checks++; if (rr(3) !== 8'hA5) begin errors++; $display("FAIL reg3: got %h want a5", rr(3)); end
        checks++; if (strobe_cnt[3] !== 1) begin errors++; $display("FAIL strobe3_cnt: got %0d want 1", strobe_cnt[3]); end
        checks++; if (strobe_q.size() !== 1) begin errors++; $display("FAIL strobe_total: got %0d want 1", strobe_q.size()); end
        checks++; if ((rw_regs & ~(128'hFF << 24)) !== '0) begin errors++; $display("FAIL other_regs: got %h want 0 outside reg3", rw_regs); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_burst_write();
        logic [31:0] rx;
        clear_mon();
        frame_begin();
        spi_bits(32'h85, 8, rx);
        spi_bits(32'h11, 8, rx);
        spi_bits(32'h22, 8, rx);
        spi_bits(32'h33, 8, rx);
        frame_end();
        checks++; if (rr(5) !== 8'h11) begin errors++; $display("FAIL reg5: got %h want 11", rr(5)); end
        checks++; if (rr(6) !== 8'h22) begin errors++; $display("FAIL reg6: got %h want 22", rr(6)); end
        checks++; if (rr(7) !== 8'h33) begin errors++; $display("FAIL reg7: got %h want 33", rr(7)); end
        checks++;
        if (strobe_q.size() !== 3) begin
            errors++; $display("FAIL burst_strobes: got %0d pulses want 3", strobe_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (strobe_q[i] !== 5 + i) begin errors++; $display("FAIL burst_order: got %0d want %0d", strobe_q[i], 5 + i); end
            end
`ifdef LT_SPI_ATOMIC_EN
            checks++; if (strobe_t[0] !== strobe_t[2]) begin errors++; $display("FAIL burst_same_cycle: got %0d/%0d want equal", strobe_t[0], strobe_t[2]); end
`else
            checks++; if (!(strobe_t[0] < strobe_t[1] && strobe_t[1] < strobe_t[2])) begin errors++; $display("FAIL burst_word_order: got %0d,%0d,%0d want increasing", strobe_t[0], strobe_t[1], strobe_t[2]); end
`endif
        end
    endtask

    task automatic test_burst_read();
        logic [31:0] rx, hi, lo, w1, w2;
        clear_mon();
        ro_regs[7:0]  = 8'h5A;
        ro_regs[15:8] = 8'hC3;
        frame_begin();
        spi_bits(32'h10, 8, rx);
        spi_bits(32'h0, 4, hi);
        ro_regs[7:0] = 8'h00;
        spi_bits(32'h0, 4, lo);
        spi_bits(32'h0, 8, w1);
        frame_end();
        checks++; if ({hi[3:0], lo[3:0]} !== 8'h5A) begin errors++; $display("FAIL read_ro0: got %h want 5a", {hi[3:0], lo[3:0]}); end
        checks++; if (w1[7:0] !== 8'hC3) begin errors++; $display("FAIL read_ro1: got %h want c3", w1[7:0]); end
        frame_begin();
        spi_bits(32'h05, 8, rx);
        spi_bits(32'h0, 8, w1);
        spi_bits(32'h0, 8, w2);
        spi_bits(32'h0, 8, rx);
        frame_end();
        checks++; if ({w1[7:0], w2[7:0], rx[7:0]} !== 24'h112233) begin errors++; $display("FAIL read_rw: got %h want 112233", {w1[7:0], w2[7:0], rx[7:0]}); end
        checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL read_strobes: got %0d want 0", strobe_q.size()); end
    endtask

    task automatic test_illegal();
        logic [31:0] rx, w1;
        clear_mon();
        frame_begin(); spi_bits(32'h90, 8, rx); spi_bits(32'hFF, 8, rx); frame_end();
        frame_begin(); spi_bits(32'hFF, 8, rx); spi_bits(32'h77, 8, rx); frame_end();
        checks++; if (rw_regs !== 128'h0000_0000_0000_0000_3322_1100_A500_0000) begin errors++; $display("FAIL illegal_regs: got %h", rw_regs); end
        checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL illegal_strobes: got %0d want 0", strobe_q.size()); end
        frame_begin(); spi_bits(32'h7F, 8, rx); spi_bits(32'h0, 8, w1); frame_end();
        checks++; if (w1[7:0] !== 8'h00) begin errors++; $display("FAIL read_7f: got %h want 00", w1[7:0]); end
        ro_regs[63:56] = 8'h6B;
        frame_begin(); spi_bits(32'h17, 8, rx); spi_bits(32'h0, 8, w1); spi_bits(32'h0, 8, rx); frame_end();
        checks++; if (w1[7:0] !== 8'h6B) begin errors++; $display("FAIL read_last_ro: got %h want 6b", w1[7:0]); end
        checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL read_past_ro: got %h want 00", rx[7:0]); end
        frame_begin(); spi_bits(32'hFF, 8, rx); spi_bits(32'h77, 8, rx); spi_bits(32'h99, 8, rx); frame_end();
        checks++; if (rr(0) !== 8'h99) begin errors++; $display("FAIL wrap_reg0: got %h want 99", rr(0)); end
        checks++; if (strobe_q.size() !== 1 || strobe_cnt[0] !== 1) begin errors++; $display("FAIL wrap_strobe: got %0d pulses want 1 on reg0", strobe_q.size()); end
        frame_begin(); spi_bits(32'h7F, 8, rx); spi_bits(32'h0, 8, w1); spi_bits(32'h0, 8, rx); frame_end();
        checks++; if ({w1[7:0], rx[7:0]} !== 16'h0099) begin errors++; $display("FAIL wrap_read: got %h want 0099", {w1[7:0], rx[7:0]}); end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        clear_mon();
        frame_begin(); spi_bits(32'h82, 8, rx); spi_bits(32'hA, 4, rx); frame_end();
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL abort_ferr: got %0d want 1", ferr_cnt); end
        checks++; if (rr(2) !== 8'h00) begin errors++; $display("FAIL abort_reg2: got %h want 00", rr(2)); end
        checks++; if (strobe_q.size() !== 0) begin errors++; $display("FAIL abort_strobe: got %0d want 0", strobe_q.size()); end
        frame_begin(); spi_bits(32'h84, 8, rx); frame_end();
        frame_begin(); spi_bits(32'h82, 8, rx); spi_bits(32'h3C, 8, rx); frame_end();
        checks++; if (rr(2) !== 8'h3C) begin errors++; $display("FAIL after_abort_reg2: got %h want 3c", rr(2)); end
        checks++; if (strobe_cnt[2] !== 1) begin errors++; $display("FAIL after_abort_strobe: got %0d want 1", strobe_cnt[2]); end
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL boundary_ferr: got %0d want 1", ferr_cnt); end
    endtask

    task automatic test_commit_mode();
        logic [31:0] rx;
        clear_mon();
        frame_begin();
        spi_bits(32'h80, 8, rx);
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h02, 8, rx);
        #(H);
`ifdef LT_SPI_ATOMIC_EN
        checks++; if ({rr(1), rr(0)} !== 16'h0099) begin errors++; $display("FAIL atomic_pre: got %h want 0099", {rr(1), rr(0)}); end
`else
        checks++; if ({rr(1), rr(0)} !== 16'h0201) begin errors++; $display("FAIL per_word_pre: got %h want 0201", {rr(1), rr(0)}); end
`endif
        frame_end();
        checks++; if ({rr(1), rr(0)} !== 16'h0201) begin errors++; $display("FAIL commit_regs: got %h want 0201", {rr(1), rr(0)}); end
        checks++;
        if (strobe_t.size() !== 2) begin
            errors++; $display("FAIL commit_strobes: got %0d want 2", strobe_t.size());
        end else begin
`ifdef LT_SPI_ATOMIC_EN
            checks++; if (strobe_t[0] !== strobe_t[1]) begin errors++; $display("FAIL atomic_same_cycle: got %0d/%0d want equal", strobe_t[0], strobe_t[1]); end
`else
            checks++; if (strobe_t[0] >= strobe_t[1]) begin errors++; $display("FAIL per_word_cycles: got %0d/%0d want increasing", strobe_t[0], strobe_t[1]); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx;
        frame_begin(); spi_bits(32'h88, 8, rx); spi_bits(32'hC4, 8, rx); frame_end();
        frame_begin(); spi_bits(32'h08, 8, rx);
        #(H);
        checks++; if (bus.MySPI_sdo !== 1'b1) begin errors++; $display("FAIL pre_reset_sdo: got %b want 1", bus.MySPI_sdo); end
        spi_bits(32'h5, 3, rx);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (rw_regs !== '0) begin errors++; $display("FAIL mid_reset_regs: got %h want 0", rw_regs); end
        checks++; if (bus.MySPI_sdo !== 1'b0) begin errors++; $display("FAIL mid_reset_sdo: got %b want 0", bus.MySPI_sdo); end
        checks++; if (wr_strobe !== '0 || frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses: got %h/%b want 0/0", wr_strobe, frame_err); end
        #6;
        rst = 1'b0;
        bus.MySPI_cs = 1'b1;
        #(4*H);
        clear_mon();
        frame_begin(); spi_bits(32'h81, 8, rx); spi_bits(32'h5E, 8, rx); frame_end();
        checks++; if (rw_regs !== (128'h5E << 8)) begin errors++; $display("FAIL post_reset_frame: got %h want reg1=5e only", rw_regs); end
        checks++; if (strobe_q.size() !== 1 || strobe_cnt[1] !== 1) begin errors++; $display("FAIL post_reset_strobe: got %0d pulses want 1 on reg1", strobe_q.size()); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL post_reset_ferr: got %0d want 0", ferr_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_illegal();
        test_abort();
        test_commit_mode();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
